// File: rtl/bbc_board_pkg.sv
// bbc_board_pkg: shared constants, types and scancode table
// for the BBC Micro board shell and its core.
package bbc_board_pkg;

    localparam int KEY_ROWS = 8;
    localparam int KEY_COLS = 10;
    localparam int KEY_BITS = KEY_ROWS * KEY_COLS;

    localparam logic [7:0] PS2_RELEASE = 8'hF0;
    localparam logic [7:0] PS2_EXTEND  = 8'hE0;
    localparam logic [7:0] PS2_RETURN  = 8'h5A;

    // Horizontal timing in ce_25m ticks, vertical timing in lines
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BACK   = 10'd48;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FRONT  = 10'd16;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BACK   = 10'd29;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FRONT  = 10'd14;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } ps2_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [3:0] col;
    } key_pos_t;

    function automatic key_pos_t key_at(input logic [2:0] row,
                                        input logic [3:0] col);
        key_pos_t p;
        p.hit = 1'b1;
        p.row = row;
        p.col = col;
        return p;
    endfunction

    function automatic key_pos_t scan_lookup(input logic [7:0] code);
        key_pos_t p;
        p = '0;
        case (code)
            8'h12, 8'h59: p = key_at(3'd0, 4'd0);
            8'h14:        p = key_at(3'd0, 4'd1);
            8'h5A:        p = key_at(3'd4, 4'd9);
            8'h29:        p = key_at(3'd6, 4'd2);
            8'h1C:        p = key_at(3'd4, 4'd1);
            8'h23:        p = key_at(3'd3, 4'd2);
            8'h21:        p = key_at(3'd5, 4'd2);
            8'h2C:        p = key_at(3'd2, 4'd3);
            8'h3A:        p = key_at(3'd6, 4'd5);
            8'h44:        p = key_at(3'd3, 4'd6);
            8'h24:        p = key_at(3'd2, 4'd2);
            8'h45:        p = key_at(3'd2, 4'd7);
            8'h16:        p = key_at(3'd3, 4'd0);
            8'h1E:        p = key_at(3'd3, 4'd1);
            8'h26:        p = key_at(3'd1, 4'd1);
            8'h25:        p = key_at(3'd1, 4'd2);
            8'h2E:        p = key_at(3'd1, 4'd3);
            8'h36:        p = key_at(3'd3, 4'd4);
            8'h55:        p = key_at(3'd1, 4'd7);
            default:      p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] key_index(input key_pos_t p);
        return {4'd0, p.row} * 7'd10 + {3'd0, p.col};
    endfunction

endpackage

// File: rtl/bbc_system.sv
// bbc_system: stand-in for the machine core exposing its board
// interface; generates fixed VGA timing and a simple SPI clock.
module bbc_system
    import bbc_board_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce_25m,
    input  logic                ce_2m,
    input  logic                ce_1m,
    input  logic [KEY_BITS-1:0] key_matrix,
    input  logic                break_n,
    input  logic [2:0]          links,
    output logic [2:0]          rgb,
    output logic                de,
    output logic                hsync_n,
    output logic                vsync_n,
    output logic                sd_sck,
    output logic                sd_mosi,
    input  logic                sd_miso
);

    localparam logic [9:0] H_START = H_SYNC + H_BACK;
    localparam logic [9:0] V_START = V_SYNC + V_BACK;

    logic [9:0] h;
    logic [9:0] v;
    logic       sck_q;
    logic       mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h      <= '0;
            v      <= '0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b1;
        end else begin
            if (ce_25m) begin
                if (h == H_TOTAL - 10'd1) begin
                    h <= '0;
                    v <= (v == V_TOTAL - 10'd1) ? '0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
            if (ce_1m && links[0]) begin
                sck_q <= ~sck_q;
            end
            if (ce_2m) begin
                mosi_q <= sd_miso;
            end
        end
    end

    assign hsync_n = (h >= H_SYNC);
    assign vsync_n = (v >= V_SYNC);
    assign de      = (h >= H_START) && (h < H_START + H_ACTIVE)
                  && (v >= V_START) && (v < V_START + V_ACTIVE);
    assign rgb     = h[5:3] ^ {|key_matrix, ~break_n, links[2] ^ links[1]};
    assign sd_sck  = sck_q;
    assign sd_mosi = mosi_q;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: synchronises the PS/2 pins and deframes scancodes,
// dropping frames with a bad stop bit or a mid-frame stall.
module ps2_rx
    import bbc_board_pkg::*;
#(
    parameter int TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       valid
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] idle_cnt;

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            state     <= RX_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            idle_cnt  <= '0;
            code      <= '0;
            valid     <= 1'b0;
        end else begin
            valid     <= 1'b0;
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            if (fall) begin
                idle_cnt <= '0;
                case (state)
                    RX_IDLE: begin
                        if (!bit_in) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift <= {bit_in, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    RX_PARITY: state <= RX_STOP;
                    RX_STOP: begin
                        state <= RX_IDLE;
                        if (bit_in) begin
                            code  <= shift;
                            valid <= 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end else if (state != RX_IDLE) begin
                // a stalled frame is abandoned so the next start bit resyncs
                if (idle_cnt == T_LAST) begin
                    state    <= RX_IDLE;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bbc_board_top.sv
// bbc_board_top: board shell around bbc_system - clock enables,
// reset sync, PS/2 keyboard matrix, VGA pins, SD pins, buttons.
module bbc_board_top
    import bbc_board_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int PS2_TIMEOUT = 200000,
    parameter int DEBOUNCE    = 1000000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic [3:0] SW,
    input  logic       BTNC,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNL,
    input  logic       BTNR,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    inout  wire  [9:7] JC
);

    localparam int DIV_25M = CLK_HZ / 25000000;
    localparam int DIV_2M  = CLK_HZ / 2000000;
    localparam int W25     = $clog2(DIV_25M);
    localparam int W2      = $clog2(DIV_2M);
    localparam logic [W25-1:0] LAST_25M = W25'(DIV_25M - 1);
    localparam logic [W2-1:0]  LAST_2M  = W2'(DIV_2M - 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

    logic                clk;
    logic [1:0]          rst_sync;
    logic                rst_n;
    logic [W25-1:0]      cnt_25m;
    logic [W2-1:0]       cnt_2m;
    logic                half_1m;
    logic                ce_25m;
    logic                ce_2m;
    logic                ce_1m;
    logic [7:0]          ps2_code;
    logic                ps2_valid;
    key_pos_t            pos;
    logic                rel_flag;
    logic                ext_flag;
    logic [KEY_BITS-1:0] key_matrix;
    logic [4:0]          btn_s0;
    logic [4:0]          btn_s1;
    logic [3:0]          sw_s0;
    logic [3:0]          sw_s1;
    logic [DW-1:0]       db_cnt;
    logic                btnc_stable;
    logic                break_n;
    logic [2:0]          links;
    logic                miso_s0;
    logic                sd_miso;
    logic [2:0]          core_rgb;
    logic                core_de;
    logic                core_hsync_n;
    logic                core_vsync_n;
    logic                core_sd_sck;
    logic                core_sd_mosi;
    logic                unused_pins;

    assign clk = CLK100MHZ;

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // ce_1m lands on every other ce_2m so the two stay phase-locked
    assign ce_25m = (cnt_25m == LAST_25M);
    assign ce_2m  = (cnt_2m == LAST_2M);
    assign ce_1m  = ce_2m & half_1m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_25m <= '0;
            cnt_2m  <= '0;
            half_1m <= 1'b0;
        end else begin
            cnt_25m <= ce_25m ? '0 : cnt_25m + 1'b1;
            cnt_2m  <= ce_2m ? '0 : cnt_2m + 1'b1;
            if (ce_2m) begin
                half_1m <= ~half_1m;
            end
        end
    end

    ps2_rx #(
        .TIMEOUT (PS2_TIMEOUT)
    ) u_ps2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (PS2_CLK),
        .ps2_data (PS2_DATA),
        .code     (ps2_code),
        .valid    (ps2_valid)
    );

    assign pos = scan_lookup(ps2_code);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_matrix <= '0;
            rel_flag   <= 1'b0;
            ext_flag   <= 1'b0;
        end else if (ps2_valid) begin
            unique case (1'b1)
                (ps2_code == PS2_RELEASE): rel_flag <= 1'b1;
                (ps2_code == PS2_EXTEND):  ext_flag <= 1'b1;
                default: begin
                    // keypad ENTER (E0 5A) doubles as RETURN
                    if (pos.hit && (!ext_flag || ps2_code == PS2_RETURN)) begin
                        key_matrix[key_index(pos)] <= ~rel_flag;
                    end
                    rel_flag <= 1'b0;
                    ext_flag <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s0      <= '0;
            btn_s1      <= '0;
            sw_s0       <= '0;
            sw_s1       <= '0;
            db_cnt      <= '0;
            btnc_stable <= 1'b0;
            miso_s0     <= 1'b1;
            sd_miso     <= 1'b1;
        end else begin
            btn_s0  <= {BTNR, BTNL, BTND, BTNU, BTNC};
            btn_s1  <= btn_s0;
            sw_s0   <= SW;
            sw_s1   <= sw_s0;
            miso_s0 <= JC[9];
            sd_miso <= miso_s0;
            if (btn_s1[0] == btnc_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btnc_stable <= btn_s1[0];
                db_cnt      <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign break_n     = ~btnc_stable;
    assign links       = sw_s1[2:0];
    assign unused_pins = ^{btn_s1[4:1], sw_s1[3]};

    bbc_system u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce_25m     (ce_25m),
        .ce_2m      (ce_2m),
        .ce_1m      (ce_1m),
        .key_matrix (key_matrix),
        .break_n    (break_n),
        .links      (links),
        .rgb        (core_rgb),
        .de         (core_de),
        .hsync_n    (core_hsync_n),
        .vsync_n    (core_vsync_n),
        .sd_sck     (core_sd_sck),
        .sd_mosi    (core_sd_mosi),
        .sd_miso    (sd_miso)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else begin
            VGA_R  <= {4{core_rgb[2] & core_de}};
            VGA_G  <= {4{core_rgb[1] & core_de}};
            VGA_B  <= {4{core_rgb[0] & core_de}};
            VGA_HS <= core_hsync_n;
            VGA_VS <= core_vsync_n;
        end
    end

    assign JC[7] = rst_n ? core_sd_sck : 1'b0;
    assign JC[8] = rst_n ? core_sd_mosi : 1'b1;

endmodule

// File: tb/tb_bbc_board_top.sv
// tb_bbc_board_top: directed checks of reset, VGA timing, PS/2
// key matrix, video formatting, SD pins and BREAK debounce.
`timescale 1ns/1ps
module tb_bbc_board_top;

    localparam int HALF = 40;
    localparam int Q    = 20;

    logic       clk = 1'b0;
    logic       cpu_resetn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] sw;
    logic       btnc, btnu, btnd, btnl, btnr;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs;
    logic       miso_drv;
    wire  [9:7] jc;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int codes  = 0;

    assign jc[9] = miso_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dut.ps2_valid) codes++;

    bbc_board_top #(
        .CLK_HZ      (100000000),
        .PS2_TIMEOUT (2000),
        .DEBOUNCE    (50)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (cpu_resetn),
        .PS2_CLK    (ps2_clk),
        .PS2_DATA   (ps2_data),
        .SW         (sw),
        .BTNC       (btnc),
        .BTNU       (btnu),
        .BTND       (btnd),
        .BTNL       (btnl),
        .BTNR       (btnr),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .JC         (jc)
    );

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] kb(input int i);
        logic [79:0] one;
        one = 80'd1;
        return one << i;
    endfunction

    task automatic wait_hs(input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (vga_hs == lvl) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic wait_vs(input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (vga_vs == lvl) begin
                at = cyc;
                return;
            end
        end
    endtask

    // ends right after the last falling edge, PS2 clock left low
    task automatic ps2_bits(input logic [7:0] b, input logic stop,
                            input int nbits);
        logic [10:0] fr;
        fr = {stop, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (Q) @(negedge clk);
            ps2_clk = 1'b0;
            if (i != nbits - 1) begin
                repeat (HALF) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (Q) @(negedge clk);
            end
        end
    endtask

    task automatic ps2_end();
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, output logic [79:0] seen);
        ps2_bits(b, 1'b1, 11);
        repeat (4) @(posedge clk);
        #1;
        seen = dut.key_matrix;
        ps2_end();
    endtask

    logic [79:0] seen;
    int t0, t1, t2, t3, c0;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        cpu_resetn = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        sw         = 4'b0000;
        {btnc, btnu, btnd, btnl, btnr} = '0;
        miso_drv   = 1'b1;

        repeat (50) @(negedge clk);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rst_jc", jc[8:7], 2'b10);
        chk("rst_matrix", dut.key_matrix, 0);
        repeat (50) @(negedge clk);
        cpu_resetn = 1'b1;

        wait_hs(1'b0, t0);
        chk("vs_with_hs", vga_vs, 0);
        wait_hs(1'b1, t1);
        wait_hs(1'b0, t2);
        wait_vs(1'b1, t3);
        chk("hs_low", t1 - t0, 384);
        chk("hs_period", t2 - t0, 3200);
        chk("vs_low", t3 - t0, 6400);
        chk("break_idle", dut.break_n, 1);

        send(8'h1C, seen);
        chk("make_a", seen, kb(41));
        send(8'hF0, seen);
        chk("f0_nochange", seen, kb(41));
        send(8'h1C, seen);
        chk("break_a", seen, 0);

        send(8'h12, seen);
        chk("make_shift", seen, kb(0));
        send(8'h55, seen);
        chk("shift_tap", seen, kb(0) | kb(17));
        send(8'hF0, seen);
        send(8'h55, seen);
        chk("tap_release", seen, kb(0));
        send(8'hF0, seen);
        send(8'h12, seen);
        chk("all_clear", seen, 0);

        send(8'hE0, seen);
        send(8'h1C, seen);
        chk("ext_ignored", seen, 0);
        send(8'hE0, seen);
        send(8'h5A, seen);
        chk("ext_return", seen, kb(49));
        send(8'hE0, seen);
        send(8'hF0, seen);
        send(8'h5A, seen);
        chk("ext_return_rel", seen, 0);

        ps2_bits(8'h1C, 1'b0, 11);
        ps2_end();
        chk("bad_stop", dut.key_matrix, 0);
        ps2_bits(8'h16, 1'b1, 5);
        ps2_end();
        repeat (2200) @(negedge clk);
        chk("stall", dut.key_matrix, 0);
        send(8'h5A, seen);
        chk("after_stall", seen, kb(49));
        send(8'hF0, seen);
        send(8'h5A, seen);
        chk("return_rel", seen, 0);

        c0 = codes;
        for (int i = 0; i < 24; i++) begin
            repeat (HALF) @(negedge clk);
            ps2_clk = ~ps2_clk;
        end
        repeat (20) @(negedge clk);
        chk("freerun_codes", codes - c0, 0);
        chk("freerun_matrix", dut.key_matrix, 0);

        @(negedge clk);
        force dut.core_de  = 1'b1;
        force dut.core_rgb = 3'b101;
        @(posedge clk);
        #1;
        chk("vid_de1", {vga_r, vga_g, vga_b}, 12'hF0F);
        @(negedge clk);
        force dut.core_de  = 1'b0;
        force dut.core_rgb = 3'b111;
        @(posedge clk);
        #1;
        chk("vid_de0", {vga_r, vga_g, vga_b}, 12'h000);
        release dut.core_de;
        release dut.core_rgb;

        @(negedge clk);
        force dut.core_sd_sck  = 1'b1;
        force dut.core_sd_mosi = 1'b0;
        #1;
        chk("sd_pins_a", jc[8:7], 2'b01);
        force dut.core_sd_sck  = 1'b0;
        force dut.core_sd_mosi = 1'b1;
        #1;
        chk("sd_pins_b", jc[8:7], 2'b10);
        release dut.core_sd_sck;
        release dut.core_sd_mosi;

        @(negedge clk);
        miso_drv = 1'b0;
        @(posedge clk);
        #1;
        chk("miso_1clk", dut.sd_miso, 1);
        @(posedge clk);
        #1;
        chk("miso_2clk", dut.sd_miso, 0);
        @(negedge clk);
        miso_drv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("miso_back", dut.sd_miso, 1);

        @(negedge clk);
        btnc = 1'b1;
        repeat (20) @(negedge clk);
        chk("btn_bounce", dut.break_n, 1);
        repeat (60) @(negedge clk);
        chk("btn_press", dut.break_n, 0);
        btnc = 1'b0;
        repeat (80) @(negedge clk);
        chk("btn_release", dut.break_n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bbc_board_top.md
Name: bbc_board_top

Overview:
- Board-level shell of the FPGA BBC Micro. It sits between the board pins and the existing machine core `bbc_system`, which is instantiated here and specified elsewhere.
- It owns clock-enable generation, reset synchronisation, PS/2 keyboard reception and its mapping onto the BBC key matrix, VGA pin formatting, the SD/SPI pin mapping on the JC header, and switch/button conditioning.
- It is the synthesis top for a 100 MHz board with VGA, PS/2, SD on JC, 4 switches and 5 buttons.

Parameters:
- CLK_HZ, 100000000, board clock frequency.
- PS2_TIMEOUT, 200000, idle clocks (2 ms) after which a partial PS/2 frame is discarded.
- DEBOUNCE, 1000000, clocks a button must be stable (10 ms) before a change is accepted.

Ports:
- CLK100MHZ  in  1  system clock, the only clock.
- CPU_RESETN  in  1  asynchronous active-low reset.
- PS2_CLK  in  1  keyboard clock, asynchronous to CLK100MHZ.
- PS2_DATA  in  1  keyboard data.
- SW  in  4  SW[2:0] BBC startup link bits passed to the core; SW[3] reserved, ignored.
- BTNC  in  1  BREAK key.
- BTNU, BTND, BTNL, BTNR  in  1 each  reserved; synchronised, unused.
- VGA_R, VGA_G, VGA_B  out  4 each  colour outputs.
- VGA_HS, VGA_VS  out  1 each  syncs, active low.
- JC  inout  [9:7]  JC[7]=SD SCK (out), JC[8]=SD CMD/MOSI (out), JC[9]=SD MISO (in, never driven).

Behaviour:
Reset
- CPU_RESETN asserts asynchronously; deassertion passes through a 2-flop synchroniser to form rst_n for all logic and the core.
- During reset: VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, JC[7]=0, JC[8]=1, key matrix all released, PS/2 receiver idle.

Clock enables (single-cycle pulses)
- ce_25m: every 4th clock.
- ce_2m: every 50th clock.
- ce_1m: every 100th clock, coincident with every other ce_2m.
- All counters reset to 0.

PS/2 receiver
- PS2_CLK and PS2_DATA each pass through a 2-flop synchroniser.
- Sample on each synchronised PS2_CLK falling edge. Idle until a 0 is sampled (start bit).
- Then shift 8 data bits LSB first, then 1 parity bit (ignored, not checked), then stop bit.
- Stop=1: emit 8-bit code with a 1-cycle valid. Stop=0: discard the frame.
- No falling edge for PS2_TIMEOUT clocks mid-frame: return to idle.
- The free-running PS2_CLK with data held at 1 must produce no codes.

Scancode decoder
- Code F0: set the release flag.
- Code E0: set the extended flag. Extended codes are ignored, except E0 5A, which is treated as RETURN.
- Any other code: look up (row,col) in the package table and set that matrix bit (make) or clear it (release flag set). Then clear both flags.
- Codes not in the table are ignored.
- Key matrix is 10 columns x 8 rows, 1 = pressed.
- Required table entries (row,col):
  - 12/59 SHIFT (0,0); 14 CTRL (0,1)
  - 5A RETURN (4,9); 29 SPACE (6,2)
  - 1C A (4,1); 23 D (3,2); 21 C (5,2); 2C T (2,3); 3A M (6,5); 44 O (3,6); 24 E (2,2)
  - 45 0 (2,7); 16 1 (3,0); 1E 2 (3,1); 26 3 (1,1); 25 4 (1,2); 2E 5 (1,3); 36 6 (3,4)
  - 55 -/= (1,7)

Buttons and switches
- BTNC is synchronised and debounced, then drives break_n (low while pressed) to the core.
- SW is synchronised and passed to the core as links[2:0].

Video
- The core delivers rgb[2:0] (R,G,B), de, hsync_n, vsync_n, timed on ce_25m.
- All are registered in this block (1-clock latency, applied equally to syncs and colour).
- Each VGA channel = its bit replicated 4×, forced to 0 when de=0.
- The core's frame timing is fixed as follows.
  - Line: 800 ce_25m ticks; HS low 96, back porch 48, 640 active, 16 front porch.
  - Frame: 525 lines; VS low 2 lines, 29 back-porch lines, 480 active, 14 front porch.
  - VS falls at the same clock as an HS fall.

SD
- JC[7] and JC[8] are driven from the core's sd_sck and sd_mosi.
- JC[9] is tri-stated and fed, 2-flop synchronised, to sd_miso.

Decomposition:
- Package bbc_board_pkg holds:
  - the scancode→(row,col) table as a constant function;
  - the F0 and E0 constants;
  - the matrix dimensions;
  - the VGA timing constants, shared with the core.
- One natural sub-module: ps2_rx (synchronisers, frame shift register, timeout, code/valid output).
- The decoder and remaining glue stay in this block. bbc_system is instantiated, not specified here.

Test Plan:
- Reset held 100 clocks, then released: VGA_HS=VGA_VS=1 and RGB=0 during reset; HS period 3200 clocks; VS low for exactly 2 HS periods; 525 lines between VS falls.
- PS/2 frame 0x1C sent, data changing 10 µs after PS2_CLK rises: matrix (4,1) set within 4 clocks of the stop-bit falling edge. Then F0,1C: (4,1) cleared, F0 itself changes no bit.
- Hold SHIFT (12), tap 55, release SHIFT (F0 12): (0,0) and (1,7) both set during the tap; all bits clear at the end.
- Frame with stop bit 0, and a frame stalled after 4 bits for >2 ms: no matrix change; the next valid 0x5A sets (4,9).
- De=1 with rgb=3'b101: VGA_R=F, VGA_G=0, VGA_B=F one clock later. De=0: all outputs 0 regardless of rgb.
- Core drives sd_sck/sd_mosi: JC[7]/JC[8] follow; toggling JC[9] reaches sd_miso after 2 clocks; JC[9] is never driven by the block.
